// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer owning pc, ir, next-pc and retire accounting.
// Strobes decode registered state, gated by stall and reset; stall freezes every register.
module mc_seq_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000,
  parameter int                IMEM_LAT = 1,
  parameter int                DMEM_LAT = 1,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [31:0]       inst_sram_rdata,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_gr_we,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [2:0]        state,
  output logic              data_sram_we,
  output logic [31:0]       mem_rdata_q,
  input  logic [31:0]       data_sram_rdata,
  output logic              rf_we,
  output logic              retire,
  output logic [ADDR_W-1:0] retire_pc,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] IF_LAST  = LAT_W'(IMEM_LAT - 1);
  localparam logic [LAT_W-1:0] MEM_LAST = LAT_W'(DMEM_LAT - 1);

  state_t            cur;
  logic [LAT_W-1:0]  lat;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] exe_npc;
  logic              ld_q;
  logic              st_q;
  logic              fin;
  logic              go;
  logic              illegal;

  assign state          = cur;
  assign inst_sram_addr = pc;
  assign exe_npc        = br_taken ? br_target : pc + ADDR_W'(4);
  assign illegal        = (state > 3'd4);
  assign go             = resetn && !stall;

  // fin marks the last cycle of an instruction, i.e. the one whose edge returns to IF
  always_comb begin
    fin = 1'b0;
    case (cur)
      S_EXE:   fin = !(dec_is_load || dec_is_store || dec_gr_we);
      S_MEM:   fin = (lat == MEM_LAST) && !ld_q;
      S_WB:    fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  assign retire       = go && fin;
  assign retire_pc    = retire ? pc : '0;
  assign rf_we        = go && (cur == S_WB);
  assign data_sram_we = go && (cur == S_MEM) && st_q && (lat == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur         <= S_IF;
      lat         <= '0;
      pc          <= RESET_PC;
      npc         <= RESET_PC + ADDR_W'(4);
      ir          <= '0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
      mem_rdata_q <= '0;
      retire_cnt  <= '0;
    end else if (!stall || illegal) begin
      // an illegal encoding has fin=0 and falls to the default arm even when stalled
      case (cur)
        S_IF: begin
          if (lat == IF_LAST) begin
            ir  <= inst_sram_rdata;
            cur <= S_ID;
            lat <= '0;
          end else begin
            lat <= lat + LAT_W'(1);
          end
        end
        S_ID: begin
          cur <= S_EXE;
          lat <= '0;
        end
        S_EXE: begin
          npc  <= exe_npc;
          ld_q <= dec_is_load;
          st_q <= dec_is_store;
          lat  <= '0;
          if (dec_is_load || dec_is_store) cur <= S_MEM;
          else if (dec_gr_we)              cur <= S_WB;
          else                             cur <= S_IF;
        end
        S_MEM: begin
          if (lat == MEM_LAST) begin
            lat <= '0;
            if (ld_q) begin
              mem_rdata_q <= data_sram_rdata;
              cur         <= S_WB;
            end else begin
              cur <= S_IF;
            end
          end else begin
            lat <= lat + LAT_W'(1);
          end
        end
        S_WB: begin
          cur <= S_IF;
          lat <= '0;
        end
        default: begin
          cur <= S_IF;
          lat <= '0;
        end
      endcase
      // instructions retiring straight out of EXE have not written npc yet
      if (fin) begin
        pc         <= (cur == S_EXE) ? exe_npc : npc;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: directed cycle table, multi-cycle corner sequences, and a
// randomized run against an instruction-level reference model on two parameter sets.
module tb_mc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        stl  [2];
  logic        ld   [2];
  logic        sto  [2];
  logic        gwe  [2];
  logic        bt   [2];
  logic [31:0] tgt  [2];
  logic [31:0] irdat[2];
  logic [31:0] drdat[2];
  logic [31:0] iaddr[2];
  logic [31:0] ir_o [2];
  logic [31:0] pc_o [2];
  logic [31:0] mrd  [2];
  logic [31:0] rpc  [2];
  logic [2:0]  st_o [2];
  logic        we_o [2];
  logic        rf_o [2];
  logic        ret_o[2];
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  int checks = 0;
  int errors = 0;

  mc_seq_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .IMEM_LAT(1), .DMEM_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .resetn(rstn[0]), .stall(stl[0]),
    .inst_sram_addr(iaddr[0]), .inst_sram_rdata(irdat[0]), .ir(ir_o[0]), .pc(pc_o[0]),
    .dec_is_load(ld[0]), .dec_is_store(sto[0]), .dec_gr_we(gwe[0]),
    .br_taken(bt[0]), .br_target(tgt[0]), .state(st_o[0]),
    .data_sram_we(we_o[0]), .mem_rdata_q(mrd[0]), .data_sram_rdata(drdat[0]),
    .rf_we(rf_o[0]), .retire(ret_o[0]), .retire_pc(rpc[0]), .retire_cnt(cnt_a));

  mc_seq_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .IMEM_LAT(3), .DMEM_LAT(2), .CNT_W(32)) u_b (
    .clk(clk), .resetn(rstn[1]), .stall(stl[1]),
    .inst_sram_addr(iaddr[1]), .inst_sram_rdata(irdat[1]), .ir(ir_o[1]), .pc(pc_o[1]),
    .dec_is_load(ld[1]), .dec_is_store(sto[1]), .dec_gr_we(gwe[1]),
    .br_taken(bt[1]), .br_target(tgt[1]), .state(st_o[1]),
    .data_sram_we(we_o[1]), .mem_rdata_q(mrd[1]), .data_sram_rdata(drdat[1]),
    .rf_we(rf_o[1]), .retire(ret_o[1]), .retire_pc(rpc[1]), .retire_cnt(cnt_b));

  function automatic int iml(int j); return (j == 0) ? 1 : 3; endfunction
  function automatic int dml(int j); return (j == 0) ? 1 : 2; endfunction
  function automatic logic [31:0] cmask(int j); return (j == 0) ? 32'h0000000f : 32'hffffffff; endfunction
  function automatic logic [31:0] get_cnt(int j); return (j == 0) ? {28'd0, cnt_a} : cnt_b; endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(int j, logic l, logic s, logic g, logic b, logic [31:0] t);
    ld[j] = l; sto[j] = s; gwe[j] = g; bt[j] = b; tgt[j] = t;
  endtask

  task automatic do_reset(int j);
    rstn[j] = 1'b0;
    cyc();
    cyc();
    rstn[j] = 1'b1;
  endtask

  // run one instruction to completion with fixed decode inputs, bounded wait
  task automatic run_inst(int j, logic l, logic s, logic g, logic b, logic [31:0] t);
    logic got;
    got = 1'b0;
    set_dec(j, l, s, g, b, t);
    stl[j] = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (ret_o[j]) got = 1'b1;
      cyc();
    end
    chk("run_inst_retired", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic        stall, l, s, g, b;
    logic [31:0] t;
    logic [2:0]  es;
    logic        ewe, erf, eret;
    logic [31:0] epc, ecnt;
  } vec_t;

  function automatic vec_t mk(logic stall, logic l, logic s, logic g, logic b, logic [31:0] t,
                              logic [2:0] es, logic ewe, logic erf, logic eret,
                              logic [31:0] epc, logic [31:0] ecnt);
    vec_t v;
    v.stall = stall; v.l = l; v.s = s; v.g = g; v.b = b; v.t = t;
    v.es = es; v.ewe = ewe; v.erf = erf; v.eret = eret; v.epc = epc; v.ecnt = ecnt;
    return v;
  endfunction

  // instruction-level reference: per-class cycle budget, phase derived from unstalled-cycle index
  task automatic rand_run(int j, int ncyc);
    int          k, len, im, dm, cls, es;
    logic        fresh, l, s, g, b, ewe, erf, eret;
    logic [31:0] m_pc, m_cnt, nxt, e_ir, e_mrd, t;
    im = iml(j); dm = dml(j);
    do_reset(j);
    m_pc = RST_PC; m_cnt = 0; k = 0; fresh = 1'b1; len = 0; nxt = 0;
    l = 0; s = 0; g = 0; b = 0; e_ir = 0; e_mrd = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (fresh) begin
        cls = $urandom_range(0, 5);
        l = (cls == 4); s = (cls == 5); g = (cls <= 1); b = (cls == 1 || cls == 2);
        t = ($urandom_range(0, 3) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
        set_dec(j, l, s, g, b, t);
        if (l)      len = im + dm + 3;
        else if (s) len = im + dm + 2;
        else if (g) len = im + 3;
        else        len = im + 2;
        nxt = b ? t : m_pc + 32'd4;
        fresh = 1'b0;
      end
      stl[j]   = ($urandom_range(0, 3) == 0);
      irdat[j] = $urandom;
      drdat[j] = $urandom;
      #1;
      if (k < im)                            es = 0;
      else if (k == im)                      es = 1;
      else if (k == im + 1)                  es = 2;
      else if ((l || s) && k < im + 2 + dm)  es = 3;
      else                                   es = 4;
      ewe  = !stl[j] && s && (k == im + 2);
      erf  = !stl[j] && (es == 4);
      eret = !stl[j] && (k == len - 1);
      chk("rnd_state", 32'(st_o[j]), es);
      chk("rnd_dsram_we", 32'(we_o[j]), 32'(ewe));
      chk("rnd_rf_we", 32'(rf_o[j]), 32'(erf));
      chk("rnd_retire", 32'(ret_o[j]), 32'(eret));
      chk("rnd_retire_pc", rpc[j], eret ? m_pc : 32'd0);
      chk("rnd_pc", pc_o[j], m_pc);
      chk("rnd_iaddr", iaddr[j], m_pc);
      chk("rnd_cnt", get_cnt(j), m_cnt & cmask(j));
      if (!stl[j]) begin
        if (k == im - 1) e_ir = irdat[j];
        if (l && k == im + 1 + dm) e_mrd = drdat[j];
        if (eret) begin
          chk("rnd_ir", ir_o[j], e_ir);
          if (l) chk("rnd_mem_rdata_q", mrd[j], e_mrd);
        end
        k++;
        if (k == len) begin
          m_pc = nxt; m_cnt++; k = 0; fresh = 1'b1;
        end
      end
      cyc();
    end
  endtask

  localparam logic [31:0] A0 = 32'h1c000000;
  localparam logic [31:0] A4 = 32'h1c000004;
  localparam logic [31:0] A8 = 32'h1c000008;
  localparam logic [31:0] T  = 32'h1c000100;

  vec_t tbl[$];
  int   retc, rfc;

  initial begin
    for (int j = 0; j < 2; j++) begin
      rstn[j] = 1'b0; stl[j] = 1'b0; irdat[j] = '0; drdat[j] = '0;
      set_dec(j, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end

    //        stall l s g b tgt  st we rf ret pc     cnt
    tbl.push_back(mk(0,0,0,1,0,0, 0,0,0,0, A0,   0));  // add.w
    tbl.push_back(mk(0,0,0,1,0,0, 1,0,0,0, A0,   0));
    tbl.push_back(mk(0,0,0,1,0,0, 2,0,0,0, A0,   0));
    tbl.push_back(mk(0,0,0,1,0,0, 4,0,1,1, A0,   0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0, A4,   1));  // bne not taken
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0, A4,   1));
    tbl.push_back(mk(0,0,0,0,0,0, 2,0,0,1, A4,   1));
    tbl.push_back(mk(0,0,0,0,1,T, 0,0,0,0, A8,   2));  // beq taken
    tbl.push_back(mk(0,0,0,0,1,T, 1,0,0,0, A8,   2));
    tbl.push_back(mk(0,0,0,0,1,T, 2,0,0,1, A8,   2));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0, T,    3));  // st.w, first MEM stalled 3 cycles
    tbl.push_back(mk(0,0,1,0,0,0, 1,0,0,0, T,    3));
    tbl.push_back(mk(0,0,1,0,0,0, 2,0,0,0, T,    3));
    tbl.push_back(mk(1,0,1,0,0,0, 3,0,0,0, T,    3));
    tbl.push_back(mk(1,0,1,0,0,0, 3,0,0,0, T,    3));
    tbl.push_back(mk(1,0,1,0,0,0, 3,0,0,0, T,    3));
    tbl.push_back(mk(0,0,1,0,0,0, 3,1,0,1, T,    3));
    tbl.push_back(mk(0,1,0,1,0,0, 0,0,0,0, T+4,  4));  // ld.w, WB stalled once
    tbl.push_back(mk(0,1,0,1,0,0, 1,0,0,0, T+4,  4));
    tbl.push_back(mk(0,1,0,1,0,0, 2,0,0,0, T+4,  4));
    tbl.push_back(mk(0,1,0,1,0,0, 3,0,0,0, T+4,  4));
    tbl.push_back(mk(1,1,0,1,0,0, 4,0,0,0, T+4,  4));
    tbl.push_back(mk(0,1,0,1,0,0, 4,0,1,1, T+4,  4));
    tbl.push_back(mk(0,0,0,1,0,0, 0,0,0,0, T+8,  5));

    cyc();
    cyc();
    chk("rst_state", 32'(st_o[0]), 32'd0);
    chk("rst_pc", pc_o[0], RST_PC);
    chk("rst_iaddr", iaddr[0], RST_PC);
    chk("rst_ir", ir_o[0], 32'd0);
    chk("rst_cnt", get_cnt(0), 32'd0);
    chk("rst_mem_rdata_q", mrd[0], 32'd0);
    chk("rst_dsram_we", 32'(we_o[0]), 32'd0);
    chk("rst_rf_we", 32'(rf_o[0]), 32'd0);
    chk("rst_retire", 32'(ret_o[0]), 32'd0);
    chk("rst_retire_pc", rpc[0], 32'd0);
    chk("rst_b_pc", pc_o[1], RST_PC);

    rstn[0] = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      stl[0]   = tbl[i].stall;
      set_dec(0, tbl[i].l, tbl[i].s, tbl[i].g, tbl[i].b, tbl[i].t);
      irdat[0] = 32'h00100c00 + i;
      drdat[0] = 32'h50000000 + i;
      #1;
      chk($sformatf("row%0d_state", i), 32'(st_o[0]), 32'(tbl[i].es));
      chk($sformatf("row%0d_dsram_we", i), 32'(we_o[0]), 32'(tbl[i].ewe));
      chk($sformatf("row%0d_rf_we", i), 32'(rf_o[0]), 32'(tbl[i].erf));
      chk($sformatf("row%0d_retire", i), 32'(ret_o[0]), 32'(tbl[i].eret));
      chk($sformatf("row%0d_retire_pc", i), rpc[0], tbl[i].eret ? tbl[i].epc : 32'd0);
      chk($sformatf("row%0d_pc", i), pc_o[0], tbl[i].epc);
      chk($sformatf("row%0d_iaddr", i), iaddr[0], tbl[i].epc);
      chk($sformatf("row%0d_cnt", i), get_cnt(0), tbl[i].ecnt);
      cyc();
    end
    chk("tbl_ir", ir_o[0], 32'h00100c17);
    chk("tbl_mem_rdata_q", mrd[0], 32'h50000014);

    // pc wrap and 4-bit retire counter wrap
    stl[0] = 1'b0;
    do_reset(0);
    run_inst(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hfffffffc);
    chk("wrap_pc_top", pc_o[0], 32'hfffffffc);
    run_inst(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc_zero", pc_o[0], 32'd0);
    chk("wrap_iaddr_zero", iaddr[0], 32'd0);
    for (int n = 0; n < 15; n++) run_inst(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_cnt", get_cnt(0), 32'd1);
    chk("wrap_pc_after", pc_o[0], 32'h0000003c);

    // ld.w with IMEM_LAT=3, DMEM_LAT=2: 8 cycles fetch to retire
    stl[1] = 1'b0;
    set_dec(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    rstn[1] = 1'b1;
    retc = 0; rfc = 0;
    for (int c = 1; c <= 20 && retc == 0; c++) begin
      drdat[1] = 32'h70000000 + c;
      #1;
      if (rf_o[1]) rfc++;
      if (ret_o[1]) retc = c;
      cyc();
    end
    chk("ld_cycles", retc, 32'd8);
    chk("ld_rf_we_pulses", rfc, 32'd1);
    chk("ld_mem_rdata_q", mrd[1], 32'h70000007);
    chk("ld_pc_next", pc_o[1], RST_PC + 32'd4);
    chk("ld_cnt", get_cnt(1), 32'd1);

    // reset asserted during WB of a load
    repeat (7) cyc();
    chk("rwb_state_wb", 32'(st_o[1]), 32'd4);
    rstn[1] = 1'b0;
    #1;
    chk("rwb_rf_we", 32'(rf_o[1]), 32'd0);
    chk("rwb_retire", 32'(ret_o[1]), 32'd0);
    cyc();
    chk("rwb_state", 32'(st_o[1]), 32'd0);
    chk("rwb_pc", pc_o[1], RST_PC);
    chk("rwb_cnt", get_cnt(1), 32'd0);

    rand_run(0, 600);
    rand_run(1, 800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the LoongArch core.
- Owns the PC, the instruction register and the IF/ID/EXE/MEM/WB state machine.
- Generalises the fixed five-state flow with configurable instruction/data SRAM read latency, an external stall, per-class state skipping, and a retired-instruction counter.
- Sits between the SRAM interfaces and the existing decode/ALU/regfile datapath, which stays combinational and is sampled by this block.

Parameters:
- ADDR_W, 32, PC and address width
- RESET_PC, 32'h1c000000, PC value after reset
- IMEM_LAT, 1, instruction SRAM read latency in cycles (>=1)
- DMEM_LAT, 1, data SRAM access latency in cycles (>=1)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous, active-low reset
- stall  in  1  hold current state and all counters this cycle
- inst_sram_addr  out  ADDR_W  fetch address (always equals pc)
- inst_sram_rdata  in  32  fetched word
- ir  out  32  instruction register
- pc  out  ADDR_W  address of the instruction in flight
- dec_is_load  in  1  decoded ld class, sampled in EXE
- dec_is_store  in  1  decoded st class, sampled in EXE
- dec_gr_we  in  1  instruction writes GPR, sampled in EXE
- br_taken  in  1  branch/jump taken, sampled in EXE
- br_target  in  ADDR_W  target address, sampled in EXE
- state  out  3  IF=0, ID=1, EXE=2, MEM=3, WB=4
- data_sram_we  out  1  store strobe
- mem_rdata_q  out  32  latched load data
- data_sram_rdata  in  32  data SRAM read word
- rf_we  out  1  register file write strobe
- retire  out  1  one-cycle pulse when an instruction completes
- retire_pc  out  ADDR_W  pc of the retiring instruction
- retire_cnt  out  CNT_W  number of instructions retired

Behaviour:
- Reset (resetn=0 at a clk edge), including mid-instruction:
  - state=IF, pc=RESET_PC, ir=0, npc=RESET_PC+4, latency counter=0, retire_cnt=0, mem_rdata_q=0.
  - data_sram_we=0, rf_we=0, retire=0, retire_pc=0.
  - No pending write survives reset.
- Latency counter lat: cleared on every state entry; increments each non-stalled cycle in IF and MEM.
- IF:
  - inst_sram_addr=pc.
  - When lat==IMEM_LAT-1 and !stall: ir<=inst_sram_rdata, go to ID.
- ID: one cycle, then EXE. Decode inputs are derived from ir by the datapath.
- EXE: one cycle.
  - Latch npc <= br_taken ? br_target : pc+4 (wraps mod 2^ADDR_W).
  - Latch class flags.
  - Next state: load or store -> MEM; else dec_gr_we -> WB; else -> IF (retire).
- MEM:
  - data_sram_we=1 only in the first MEM cycle (lat==0) of a store, and only if !stall. A stalled first cycle re-issues on the next unstalled cycle; exactly one write-strobe cycle per store.
  - Exit when lat==DMEM_LAT-1.
  - Load exit: mem_rdata_q<=data_sram_rdata, go to WB.
  - Store exit: go to IF (retire).
- WB: rf_we=1 for exactly one non-stalled cycle, then IF (retire).
- Retire (transition back to IF):
  - retire=1 for one cycle, with retire_pc=old pc.
  - pc<=npc; retire_cnt increments and wraps at 2^CNT_W.
  - The new IF begins the next cycle.
- Stall:
  - Freezes state, lat, pc, ir, npc, retire_cnt.
  - Forces data_sram_we=0, rf_we=0, retire=0.
  - Stall has priority over every transition; reset has priority over stall.
- Cycles per instruction (no stall):
  - ALU/jirl/bl: IMEM_LAT+3
  - b/beq/bne: IMEM_LAT+2
  - load: IMEM_LAT+DMEM_LAT+3
  - store: IMEM_LAT+DMEM_LAT+2
- All strobes are registered-state decodes; no combinational path from stall to state.
- state is never outside 0..4. Illegal encodings recover to IF on the next edge.

Test Plan:
- Reset, IMEM_LAT=1; feed add.w r1,r2,r3 (0x00100c41) -> IF,ID,EXE,WB over 4 cycles; rf_we high in cycle 4 only; retire with retire_pc=0x1c000000; pc becomes 0x1c000004; retire_cnt=1.
- IMEM_LAT=3, DMEM_LAT=2; ld.w -> 8 cycles fetch-to-retire; mem_rdata_q equals data_sram_rdata sampled at the last MEM cycle; one rf_we pulse.
- st.w with stall asserted on the first MEM cycle for 3 cycles -> data_sram_we asserted exactly once, after stall drops; state held at MEM while stalled.
- beq taken, br_target=0x1c000100, at pc=0x1c000008 -> no MEM/WB, retire after 3 cycles (IMEM_LAT=1); next inst_sram_addr=0x1c000100; bne not taken -> 0x1c00000c.
- resetn low during WB of a load -> no rf_we that cycle; next cycle state=IF, pc=0x1c000000, retire_cnt=0.
- CNT_W=4; retire 17 ALU instructions -> retire_cnt reads 1 (wrap); pc at 0xfffffffc with no branch -> wraps to 0x00000000.
